// File: rtl/hit_resolver.sv
// Melee hit resolution for a single attacker/defender pair: reach test, one hit per
// attack, saturating health, hitstun countdown and an absorbing knockout state.
module hit_resolver #(
  parameter int MAX_HP         = 100,
  parameter int DAMAGE         = 10,
  parameter int HIT_RANGE      = 40,
  parameter int V_RANGE        = 32,
  parameter int HITSTUN_FRAMES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       atk_active,
  input  logic       atk_busy,
  input  logic [9:0] atk_x,
  input  logic [9:0] atk_y,
  input  logic       atk_facing_right,
  input  logic [9:0] def_x,
  input  logic [9:0] def_y,
  output logic       hitstun_active,
  output logic [5:0] hitstun_frame,
  output logic       hit_pulse,
  output logic [6:0] def_hp,
  output logic       ko
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STUN = 2'd1,
    KO   = 2'd2
  } state_t;

  localparam logic [10:0] H_REACH   = 11'(HIT_RANGE);
  localparam logic [10:0] V_REACH   = 11'(V_RANGE);
  localparam logic [6:0]  HP_INIT   = 7'(MAX_HP);
  localparam logic [6:0]  HP_DMG    = 7'(DAMAGE);
  localparam logic [5:0]  STUN_LAST = 6'(HITSTUN_FRAMES - 1);

  state_t     state_r;
  logic [5:0] count_r;
  logic       hit_latched_r;

  logic [9:0] dx_s;
  logic [9:0] dy_s;
  logic       h_ok_s;
  logic       v_ok_s;
  logic       qualify_s;
  logic       hit_s;
  logic [6:0] hp_after_s;

  // Reach test: order first, then subtract, so positions never wrap.
  always_comb begin
    dx_s   = 10'd0;
    h_ok_s = 1'b0;
    if (atk_facing_right) begin
      if (def_x >= atk_x) begin
        dx_s   = def_x - atk_x;
        h_ok_s = ({1'b0, dx_s} <= H_REACH);
      end else begin
        h_ok_s = 1'b0;
      end
    end else begin
      if (atk_x >= def_x) begin
        dx_s   = atk_x - def_x;
        h_ok_s = ({1'b0, dx_s} <= H_REACH);
      end else begin
        h_ok_s = 1'b0;
      end
    end
  end

  // Vertical offset magnitude check.
  always_comb begin
    dy_s   = 10'd0;
    v_ok_s = 1'b0;
    if (atk_y >= def_y) begin
      dy_s = atk_y - def_y;
    end else begin
      dy_s = def_y - atk_y;
    end
    v_ok_s = ({1'b0, dy_s} <= V_REACH);
  end

  // Hit qualification and saturating health after damage.
  always_comb begin
    qualify_s  = atk_active & h_ok_s & v_ok_s;
    hit_s      = SCEN & qualify_s & ~hit_latched_r & (state_r == IDLE);
    hp_after_s = 7'd0;
    if (def_hp > HP_DMG) begin
      hp_after_s = def_hp - HP_DMG;
    end else begin
      hp_after_s = 7'd0;
    end
  end

  // Defender state machine; all outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      count_r        <= 6'd0;
      hit_latched_r  <= 1'b0;
      def_hp         <= HP_INIT;
      hitstun_active <= 1'b0;
      hitstun_frame  <= 6'd0;
      hit_pulse      <= 1'b0;
      ko             <= 1'b0;
    end else begin
      hit_pulse <= hit_s;
      if (SCEN) begin
        // Latch sets even while stunned so a lingering attack cannot land later.
        if (!atk_busy) begin
          hit_latched_r <= 1'b0;
        end else if (qualify_s) begin
          hit_latched_r <= 1'b1;
        end
        case (state_r)
          IDLE: begin
            if (hit_s) begin
              def_hp <= hp_after_s;
              if (hp_after_s == 7'd0) begin
                state_r <= KO;
                ko      <= 1'b1;
              end else begin
                state_r        <= STUN;
                count_r        <= 6'd0;
                hitstun_active <= 1'b1;
                hitstun_frame  <= 6'd0;
              end
            end
          end
          STUN: begin
            if (count_r == STUN_LAST) begin
              state_r        <= IDLE;
              count_r        <= 6'd0;
              hitstun_active <= 1'b0;
              hitstun_frame  <= 6'd0;
            end else begin
              count_r        <= count_r + 6'd1;
              hitstun_frame  <= count_r + 6'd1;
            end
          end
          KO: begin
            def_hp         <= 7'd0;
            ko             <= 1'b1;
            hitstun_active <= 1'b0;
            hitstun_frame  <= 6'd0;
          end
          default: begin
            state_r        <= IDLE;
            count_r        <= 6'd0;
            hitstun_active <= 1'b0;
            hitstun_frame  <= 6'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hit_resolver.sv
// Scoreboard bench for hit_resolver: a frame-level reference model queues expected
// outputs per SCEN/reset edge and an independent monitor compares them.
module tb_hit_resolver;

  localparam int HP0   = 100;
  localparam int DMG   = 10;
  localparam int HR    = 40;
  localparam int VR    = 32;
  localparam int STUNF = 20;

  logic       clk = 1'b0;
  logic       reset, SCEN, atk_active, atk_busy, atk_facing_right;
  logic [9:0] atk_x, atk_y, def_x, def_y;
  logic       hitstun_active, hit_pulse, ko;
  logic [5:0] hitstun_frame;
  logic [6:0] def_hp;

  always #5 clk = ~clk;

  hit_resolver dut (
    .clk(clk), .reset(reset), .SCEN(SCEN),
    .atk_active(atk_active), .atk_busy(atk_busy),
    .atk_x(atk_x), .atk_y(atk_y), .atk_facing_right(atk_facing_right),
    .def_x(def_x), .def_y(def_y),
    .hitstun_active(hitstun_active), .hitstun_frame(hitstun_frame),
    .hit_pulse(hit_pulse), .def_hp(def_hp), .ko(ko)
  );

  typedef struct {
    bit pulse;
    int hp;
    bit ko;
    bit act;
    int frame;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   started  = 1'b0;
  bit   seen_scen = 1'b0;
  bit   seen_rst  = 1'b0;

  // reference model state, in frames and plain integers
  int m_hp = HP0;
  int m_stun_left = 0;
  bit m_ko = 1'b0;
  bit m_latched = 1'b0;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit in_reach(int ax, int ay, int dxp, int dyp, bit right);
    int d;
    d = right ? (dxp - ax) : (ax - dxp);
    return (d >= 0) && (d <= HR) && (iabs(ay - dyp) <= VR);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_frame(bit busy, bit active, bit right, int ax, int ay,
                             int dxp, int dyp, bit rst);
    exp_t e;
    bit   qual, hit;
    @(posedge clk); #1;
    atk_busy = busy; atk_active = active; atk_facing_right = right;
    atk_x = 10'(ax); atk_y = 10'(ay); def_x = 10'(dxp); def_y = 10'(dyp);
    SCEN = 1'b1; reset = rst;
    if (rst) begin
      m_hp = HP0; m_stun_left = 0; m_ko = 1'b0; m_latched = 1'b0; hit = 1'b0;
    end else begin
      qual = active && in_reach(ax, ay, dxp, dyp, right);
      hit  = qual && !m_latched && !m_ko && (m_stun_left == 0);
      if (!busy) m_latched = 1'b0;
      else if (qual) m_latched = 1'b1;
      if (m_stun_left > 0) m_stun_left--;
      if (hit) begin
        m_hp = (m_hp > DMG) ? (m_hp - DMG) : 0;
        if (m_hp == 0) m_ko = 1'b1;
        else m_stun_left = STUNF;
      end
    end
    e.pulse = hit;
    e.hp    = m_hp;
    e.ko    = m_ko;
    e.act   = (m_stun_left > 0);
    e.frame = e.act ? (STUNF - m_stun_left) : 0;
    q.push_back(e);
    @(posedge clk); #1;
    SCEN = 1'b0; reset = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive_frame(1'b0, 1'b0, 1'b1, 300, 360, 330, 360, 1'b0);
  endtask

  // short attack: active on the first busy frame, then enough quiet frames to clear stun
  task automatic poke(int ax, int dxp, int dyp, bit right);
    drive_frame(1'b1, 1'b1, right, ax, 360, dxp, dyp, 1'b0);
    drive_frame(1'b1, 1'b0, right, ax, 360, dxp, dyp, 1'b0);
    idle(STUNF + 2);
  endtask

  // monitor: remember which edges were SCEN/reset edges
  always @(posedge clk) begin
    seen_scen <= SCEN;
    seen_rst  <= reset;
  end

  // monitor: pop and compare after each SCEN/reset edge, else hit_pulse must be low
  always @(negedge clk) begin
    exp_t e;
    if (seen_scen || seen_rst) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL queue_empty: got output edge with no expectation at %0t", $time);
      end else begin
        e = q.pop_front();
        check("hit_pulse", 32'(hit_pulse), 32'(e.pulse));
        check("def_hp", 32'(def_hp), 32'(e.hp));
        check("ko", 32'(ko), 32'(e.ko));
        check("hitstun_active", 32'(hitstun_active), 32'(e.act));
        check("hitstun_frame", 32'(hitstun_frame), 32'(e.frame));
        started = 1'b1;
      end
    end else if (started) begin
      check("pulse_idle", 32'(hit_pulse), 32'd0);
    end
  end

  initial begin
    reset = 1'b0; SCEN = 1'b0; atk_active = 1'b0; atk_busy = 1'b0;
    atk_facing_right = 1'b1; atk_x = 10'd0; atk_y = 10'd0; def_x = 10'd0; def_y = 10'd0;
    repeat (2) @(posedge clk);
    drive_frame(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b1);

    // basic attack: busy 18 frames, active frames 4..10
    for (int f = 1; f <= 18; f++)
      drive_frame(1'b1, (f >= 4) && (f <= 10), 1'b1, 300, 360, 330, 360, 1'b0);
    idle(8);

    // reach boundaries, including a left-facing case that would hit if positions wrapped
    poke(300, 340, 360, 1'b1);
    poke(300, 341, 360, 1'b1);
    poke(300, 330, 360, 1'b0);
    poke(300, 330, 327, 1'b1);
    poke(300, 260, 392, 1'b0);
    poke(5, 1020, 360, 1'b0);

    // attack held with no frame ticks: nothing may change
    @(posedge clk); #1;
    atk_busy = 1'b1; atk_active = 1'b1; atk_facing_right = 1'b1;
    atk_x = 10'd300; atk_y = 10'd360; def_x = 10'd330; def_y = 10'd360;
    repeat (100) @(posedge clk);
    idle(1);

    // attack held past the whole stun: one hit only; then a fresh attack lands
    for (int f = 0; f < 30; f++) drive_frame(1'b1, 1'b1, 1'b1, 300, 360, 330, 360, 1'b0);
    idle(1);
    drive_frame(1'b1, 1'b1, 1'b1, 300, 360, 330, 360, 1'b0);
    idle(3);
    // a second attack during stun is ignored
    drive_frame(1'b1, 1'b1, 1'b1, 300, 360, 330, 360, 1'b0);
    idle(STUNF + 2);

    // reset mid-stun with a qualifying attack present
    drive_frame(1'b1, 1'b1, 1'b1, 300, 360, 330, 360, 1'b0);
    idle(2);
    drive_frame(1'b1, 1'b1, 1'b1, 300, 360, 330, 360, 1'b1);
    idle(1);

    // knockout path: 10 hits to zero, an 11th is ignored, then reset from KO
    for (int h = 0; h < 11; h++) poke(300, 330, 360, 1'b1);
    drive_frame(1'b1, 1'b1, 1'b1, 300, 360, 330, 360, 1'b1);
    idle(1);

    // randomized frames against the model
    for (int i = 0; i < 400; i++) begin
      int ax, ay;
      bit busy;
      ax   = 100 + $urandom_range(0, 800);
      ay   = 100 + $urandom_range(0, 800);
      busy = ($urandom_range(0, 3) != 0);
      drive_frame(busy, busy && $urandom_range(0, 1), $urandom_range(0, 1),
                  ax, ay, ax + $urandom_range(0, 100) - 50, ay + $urandom_range(0, 80) - 40,
                  $urandom_range(0, 99) == 0);
    end
    idle(2);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_drain: got %0d pending expectations expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_resolver.md
HIT_RESOLVER -- requirements
Module: hit_resolver

Interface
REQ-001 SHALL have parameter MAX_HP, default 100: defender starting health, range 1..127.
REQ-002 SHALL have parameter DAMAGE, default 10: health removed per hit, range 1..127.
REQ-003 SHALL have parameter HIT_RANGE, default 40: maximum horizontal reach of a hit, in pixels.
REQ-004 SHALL have parameter V_RANGE, default 32: maximum vertical offset of a hit, in pixels.
REQ-005 SHALL have parameter HITSTUN_FRAMES, default 20: stun length in frames, range 1..63.
REQ-006 SHALL have ports (name, direction, width, meaning):
- clk  in  1  pixel clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- SCEN  in  1  frame tick; one clk cycle per frame.
- atk_active  in  1  attacker hitbox window.
- atk_busy  in  1  attacker whole-attack window.
- atk_x  in  10  attacker x position.
- atk_y  in  10  attacker y position.
- atk_facing_right  in  1  attacker facing direction.
- def_x  in  10  defender x position.
- def_y  in  10  defender y position.
- hitstun_active  out  1  defender is stunned.
- hitstun_frame  out  6  elapsed stun frame.
- hit_pulse  out  1  one-cycle hit strobe.
- def_hp  out  7  defender health.
- ko  out  1  defender knocked out.

Function
REQ-007 SHALL evaluate inputs and advance state only on clk edges where SCEN=1; on cycles with SCEN=0 it SHALL hold all state, and hit_pulse SHALL be 0.
REQ-008 SHALL define the horizontal test as:
- facing right: def_x>=atk_x and def_x-atk_x<=HIT_RANGE.
- facing left: atk_x>=def_x and atk_x-def_x<=HIT_RANGE.
- No subtraction before the ordering compare, so there is no 10-bit wrap.
REQ-009 SHALL define the vertical test as |atk_y-def_y|<=V_RANGE, using the ordered subtraction of REQ-008.
REQ-010 SHALL define a hit as: SCEN & atk_active & horizontal test & vertical test & ~hit_latched & state==IDLE.
REQ-011 SHALL set internal hit_latched on a hit, permitting at most one hit per attack.
REQ-012 SHALL clear hit_latched on a SCEN cycle with atk_busy=0; a simultaneous hit SHALL NOT occur because atk_active implies atk_busy.
REQ-013 SHALL implement states IDLE, STUN and KO.
REQ-014 SHALL, on a hit, update def_hp to saturating def_hp-DAMAGE (0 if def_hp<=DAMAGE).
REQ-015 SHALL pulse hit_pulse=1 for exactly one clk cycle, the cycle after the detecting SCEN edge.
REQ-016 SHALL, on a hit leaving def_hp>0, enter STUN with stun counter=0.
REQ-017 SHALL, on a hit leaving def_hp=0, enter KO directly, with no stun.
REQ-018 SHALL, in STUN, drive hitstun_active=1 and hitstun_frame=counter.
REQ-019 SHALL, in STUN, increment the counter on each SCEN; on the SCEN where counter==HITSTUN_FRAMES-1 it SHALL go to IDLE and clear the counter.
REQ-020 SHALL therefore hold hitstun_active for exactly HITSTUN_FRAMES frames.
REQ-021 SHALL ignore attacks while in STUN; hit_latched still sets on the first qualifying frame so that the same attack cannot land after stun ends.
REQ-022 SHALL treat KO as absorbing until reset: ko=1, hitstun_active=0, hitstun_frame=0, def_hp=0, all attacks ignored.
REQ-023 SHALL drive hitstun_active=0 and hitstun_frame=0 in IDLE.
REQ-024 SHALL register all outputs; output latency from the detecting SCEN edge is 1 clk.

Reset
REQ-025 SHALL, on reset=1 at a clk edge, load state=IDLE, def_hp=MAX_HP, hit_latched=0, stun counter=0, hitstun_active=0, hitstun_frame=0, hit_pulse=0, ko=0.
REQ-026 SHALL give reset priority over SCEN and any hit in the same cycle, including mid-STUN or in KO.

Verification
REQ-027 SHALL cover: atk_x=300, atk_y=def_y=360, facing right, def_x=330; atk_busy for 18 frames, atk_active on frames 4-10 -> one hit_pulse, def_hp 100->90, hitstun_active for 20 SCENs with hitstun_frame 0..19, then IDLE.
REQ-028 SHALL cover reach boundaries: def_x=340 -> hit; def_x=341 -> no hit; facing left with def_x=330 -> no hit; def_y=atk_y-33 -> no hit.
REQ-029 SHALL cover: atk_active held high with SCEN low for 100 cycles -> no state change; a second attack during STUN -> ignored.
REQ-030 SHALL cover: atk_busy still high after stun ends -> no rehit; atk_busy drops, then a new attack -> hit, def_hp decrements again.
REQ-031 SHALL cover: 10 spaced hits -> def_hp reaches 0, ko=1 with no stun; an 11th attack -> no hit_pulse, def_hp stays 0.
REQ-032 SHALL cover: reset asserted coinciding with SCEN and a qualifying hit in STUN or KO -> next cycle def_hp=100, ko=0, hitstun_active=0, hit_pulse=0.
